toggle_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered toggle output `a` among `N` requesters. Each granted requester receives a burst of `burst_len` consecutive toggles, followed by a mandatory one-cycle gap before the next grant. The block sits between requester logic and the single shared toggle flop, and is the only writer of `a`.

---
 rtl/toggle_arbiter.sv | 133 +++++++++++++
 tb/tb_toggle_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_arbiter.sv
// rtl/toggle_arbiter.sv - round-robin arbiter sharing one registered toggle output among N requesters
module toggle_arbiter #(
  parameter int N       = 4,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [BURST_W-1:0] burst_len,
  output logic [N-1:0]       grant,
  output logic               busy,
  output logic [N-1:0]       done,
  output logic               a
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [N-1:0]       done_q, done_d;
  logic               a_q, a_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;
  logic [N-1:0]       win_onehot;
  logic [BURST_W-1:0] load_len;

  // Round-robin pick: first requester at or above the pointer, wrapping modulo N
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(N)) begin
        scan_sum = scan_sum - (PTR_W+1)'(N);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign win_onehot = N'(1) << win_idx;
  // A zero burst length still yields one toggle
  assign load_len   = (burst_len == '0) ? BURST_W'(1) : burst_len;

  // Next-state logic: grant selection, toggling during the burst, one-cycle gap
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    a_d     = a_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          owner_d = win_idx;
          cnt_d   = load_len;
          ptr_d   = (win_idx == PTR_W'(N-1)) ? '0 : win_idx + 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req[owner_q]) begin
          a_d   = ~a_q;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) begin
            grant_d = '0;
            done_d  = grant_q;
            state_d = GAP;
          end
        end else begin
          // Owner dropped its request: end the burst quietly, a keeps its value
          grant_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      a_q     <= a_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign a     = a_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_toggle_arbiter.sv
// tb/tb_toggle_arbiter.sv - scoreboard bench for toggle_arbiter
module tb_toggle_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] burst_len;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] done;
  logic       a;

  int vectors;
  int miscompares;
  logic exp_a;

  typedef struct packed {
    logic       is_done;
    logic [3:0] val;
    logic       a_val;
  } ev_t;

  ev_t exp_q[$];

  toggle_arbiter #(.N(4), .BURST_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .burst_len (burst_len),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .a         (a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_grant(input logic [3:0] g);
    ev_t e;
    e.is_done = 1'b0;
    e.val     = g;
    e.a_val   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] d, input logic av);
    ev_t e;
    e.is_done = 1'b1;
    e.val     = d;
    e.a_val   = av;
    exp_q.push_back(e);
  endtask

  // Monitor: every new grant and every done pulse is popped against the scoreboard
  logic [3:0] prev_grant;
  initial prev_grant = '0;
  always @(negedge clk) begin
    ev_t e;
    if (grant != 4'b0 && prev_grant == 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", {28'b0, grant}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_event_kind", {31'b0, e.is_done}, 32'h0);
        chk("grant_event_val", {28'b0, grant}, {28'b0, e.val});
      end
    end
    if (done != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {28'b0, done}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("done_event_kind", {31'b0, e.is_done}, 32'h1);
        chk("done_event_val", {28'b0, done}, {28'b0, e.val});
        chk("done_event_a", {31'b0, a}, {31'b0, e.a_val});
      end
    end
    prev_grant = grant;
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_a       = 1'b0;
    rst_n       = 1'b0;
    req         = 4'b0;
    burst_len   = 4'd0;
    tick();
    tick();
    chk("reset_grant", {28'b0, grant}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {28'b0, done}, 32'h0);
    chk("reset_a", {31'b0, a}, 32'h0);

    // Single requester, burst of 3
    rst_n     = 1'b1;
    req       = 4'b0001;
    burst_len = 4'd3;
    push_grant(4'b0001);
    push_done(4'b0001, 1'b1);
    tick();
    chk("t1_grant", {28'b0, grant}, 32'h1);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("t1_a0", {31'b0, a}, 32'h1);
    tick();
    chk("t1_a1", {31'b0, a}, 32'h0);
    tick();
    chk("t1_a2", {31'b0, a}, 32'h1);
    chk("t1_busy_done", {31'b0, busy}, 32'h1);
    req = 4'b0;
    tick();
    chk("t1_done_clear", {28'b0, done}, 32'h0);
    chk("t1_busy_low", {31'b0, busy}, 32'h0);

    // All requesting, burst of 1, from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    exp_a     = 1'b0;
    req       = 4'b1111;
    burst_len = 4'd1;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (g % 4);
      exp_a = ~exp_a;
      push_grant(eg);
      push_done(eg, exp_a);
    end
    exp_a = 1'b0;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (g % 4);
      tick();
      chk("t2_grant", {28'b0, grant}, {28'b0, eg});
      exp_a = ~exp_a;
      tick();
      chk("t2_a", {31'b0, a}, {31'b0, exp_a});
      if (g == 4) req = 4'b0;
      tick();
    end

    // Zero burst length gives one toggle (a: 1 -> 0)
    req       = 4'b0100;
    burst_len = 4'd0;
    push_grant(4'b0100);
    push_done(4'b0100, 1'b0);
    tick();
    chk("t3_grant", {28'b0, grant}, 32'h4);
    tick();
    req = 4'b0;
    tick();
    tick();
    chk("t3_a_once", {31'b0, a}, 32'h0);

    // Abort after 3 toggles; requester 2 then wins over requester 0
    req       = 4'b0010;
    burst_len = 4'd8;
    push_grant(4'b0010);
    tick();
    chk("t4_grant", {28'b0, grant}, 32'h2);
    tick();
    tick();
    tick();
    chk("t4_a_before", {31'b0, a}, 32'h1);
    req = 4'b0101;
    tick();
    chk("t4_abort_grant", {28'b0, grant}, 32'h0);
    chk("t4_abort_a", {31'b0, a}, 32'h1);
    chk("t4_abort_done", {28'b0, done}, 32'h0);
    chk("t4_abort_busy", {31'b0, busy}, 32'h1);
    burst_len = 4'd1;
    push_grant(4'b0100);
    push_done(4'b0100, 1'b0);
    tick();
    chk("t4_idle_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("t4_next_grant", {28'b0, grant}, 32'h4);
    tick();
    req = 4'b0;
    tick();
    tick();

    // Asynchronous reset between edges mid-burst
    req       = 4'b0001;
    burst_len = 4'd5;
    push_grant(4'b0001);
    tick();
    tick();
    chk("t5_a_mid", {31'b0, a}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", {28'b0, grant}, 32'h0);
    chk("t5_rst_busy", {31'b0, busy}, 32'h0);
    chk("t5_rst_done", {28'b0, done}, 32'h0);
    chk("t5_rst_a", {31'b0, a}, 32'h0);
    tick();
    rst_n     = 1'b1;
    req       = 4'b1001;
    burst_len = 4'd1;
    push_grant(4'b0001);
    push_done(4'b0001, 1'b1);
    tick();
    chk("t5_post_grant", {28'b0, grant}, 32'h1);
    tick();
    req = 4'b0;
    tick();
    tick();

    // burst_len changed after the grant edge is ignored
    req       = 4'b0010;
    burst_len = 4'd2;
    push_grant(4'b0010);
    push_done(4'b0010, 1'b1);
    tick();
    chk("t6_grant", {28'b0, grant}, 32'h2);
    burst_len = 4'd15;
    tick();
    chk("t6_a0", {31'b0, a}, 32'h0);
    chk("t6_no_early_done", {28'b0, done}, 32'h0);
    tick();
    chk("t6_a1", {31'b0, a}, 32'h1);
    chk("t6_grant_fall", {28'b0, grant}, 32'h0);
    chk("t6_busy_gap", {31'b0, busy}, 32'h1);
    req = 4'b0;
    tick();
    chk("t6_busy_low", {31'b0, busy}, 32'h0);
    tick();
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
